// File: rtl/fp32_settle_monitor.sv
// Watches a converter's IEEE-754 output on its slow tick and reports when the
// word has held bit-identical for STABLE_COUNT tick-to-tick comparisons, or a timeout.
module fp32_settle_monitor #(
  parameter int STABLE_COUNT  = 20,
  parameter int TIMEOUT_TICKS = 400,
  parameter int CNT_W         = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             tick_in,
  input  logic [31:0]      fp_in,
  output logic             busy,
  output logic             settled_valid,
  input  logic             settled_ready,
  output logic [31:0]      settled_value,
  output logic [2:0]       settled_class,
  output logic             timeout,
  output logic [CNT_W-1:0] stable_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_TRACK = 3'd2,
    S_HOLD  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  // Handshake: settled_value/settled_class are stable whenever settled_valid is
  // high; a transfer happens in a cycle with settled_valid & settled_ready both high.

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SETTLE_AT  = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(TIMEOUT_TICKS);

  state_t           state_q;
  logic             tick_q;
  logic [31:0]      last_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] stable_q;
  logic [31:0]      value_q;
  logic [2:0]       class_q;
  logic             busy_q;
  logic             valid_q;
  logic             timeout_q;

  logic             tick_rise;
  logic             fp_is_nan;
  logic             fp_same;
  logic [CNT_W-1:0] stable_d;
  logic [CNT_W-1:0] tick_cnt_d;
  logic [2:0]       class_d;
  logic             exp_zero;
  logic             exp_ones;
  logic             man_nz;

  always_comb begin
    tick_rise  = tick_in & ~tick_q;
    exp_zero   = ~|fp_in[30:23];
    exp_ones   = &fp_in[30:23];
    man_nz     = |fp_in[22:0];
    fp_is_nan  = exp_ones & man_nz;
    // Signed zeros differ bitwise, so they never count as a repeat.
    fp_same    = (fp_in == last_q) & ~fp_is_nan;
    stable_d   = '0;
    if (fp_same) begin
      stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + 1'b1;
    end
    tick_cnt_d = tick_cnt_q + 1'b1;
    class_d    = 3'd2;
    if (exp_zero) begin
      class_d = man_nz ? 3'd1 : 3'd0;
    end else if (exp_ones) begin
      if (!man_nz) begin
        class_d = 3'd3;
      end else begin
        class_d = fp_in[22] ? 3'd4 : 3'd5;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tick_q     <= 1'b0;
      last_q     <= '0;
      tick_cnt_q <= '0;
      stable_q   <= '0;
      value_q    <= '0;
      class_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tick_q <= tick_in;
      case (state_q)
        S_IDLE, S_FAIL: begin
          if (start) begin
            state_q    <= S_ARM;
            stable_q   <= '0;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
            timeout_q  <= 1'b0;
          end
        end
        S_ARM: begin
          // A restart takes priority over a coincident tick.
          if (start) begin
            stable_q   <= '0;
            tick_cnt_q <= '0;
          end else if (tick_rise) begin
            state_q    <= S_TRACK;
            last_q     <= fp_in;
            tick_cnt_q <= CNT_W'(1);
            stable_q   <= '0;
          end
        end
        S_TRACK: begin
          if (start) begin
            state_q    <= S_ARM;
            stable_q   <= '0;
            tick_cnt_q <= '0;
          end else if (tick_rise) begin
            last_q     <= fp_in;
            tick_cnt_q <= tick_cnt_d;
            stable_q   <= stable_d;
            if (stable_d == SETTLE_AT) begin
              state_q <= S_HOLD;
              value_q <= fp_in;
              class_q <= class_d;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else if (tick_cnt_d == TIMEOUT_AT) begin
              state_q   <= S_FAIL;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (settled_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          valid_q   <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign settled_valid = valid_q;
  assign settled_value = value_q;
  assign settled_class = class_q;
  assign timeout       = timeout_q;
  assign stable_cnt    = stable_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_fp32_settle_monitor.sv
// Bench for fp32_settle_monitor: random slow tick, sample-history reference model
// compared every cycle, plus directed runs pinned to hand-computed values.
module tb_fp32_settle_monitor;
  localparam int SC    = 20;
  localparam int TO    = 400;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             tick_in = 1'b0;
  logic [31:0]      fp_in = '0;
  logic             settled_ready = 1'b1;
  logic             busy;
  logic             settled_valid;
  logic [31:0]      settled_value;
  logic [2:0]       settled_class;
  logic             timeout;
  logic [CNT_W-1:0] stable_cnt;
  logic [2:0]       state_dbg;

  fp32_settle_monitor #(.STABLE_COUNT(SC), .TIMEOUT_TICKS(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tick_in(tick_in), .fp_in(fp_in),
    .busy(busy), .settled_valid(settled_valid), .settled_ready(settled_ready),
    .settled_value(settled_value), .settled_class(settled_class), .timeout(timeout),
    .stable_cnt(stable_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  done     = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // ---------------- converter stand-in ----------------
  int          fp_mode  = 0;  // 0 constant, 1 alternate a/b, 2 random sticky
  int          keep_pct = 90;
  logic [31:0] fp_a = 32'h3F80_0000;
  logic [31:0] fp_b = 32'h3F80_0001;

  task automatic next_fp();
    case (fp_mode)
      0: fp_in = fp_a;
      1: fp_in = (fp_in == fp_a) ? fp_b : fp_a;
      default: begin
        if (int'($urandom_range(0, 99)) >= keep_pct) begin
          case ($urandom_range(0, 4))
            0: fp_in = fp_a;
            1: fp_in = fp_b;
            2: fp_in = 32'h7FC0_0000;
            3: fp_in = 32'h7F80_0001;
            default: fp_in = $urandom;
          endcase
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      tick_in = 1'b1;
      next_fp();
      repeat ($urandom_range(1, 3)) @(negedge clk);
      tick_in = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  end

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ARMED = 1, M_TRACK = 2, M_HOLD = 3, M_FAIL = 4;
  int          m_phase = M_IDLE;
  logic [31:0] samp_q[$];
  logic        m_tick_prev = 1'b0;
  int          m_stable = 0;
  logic [31:0] m_value = '0;
  logic [2:0]  m_class = '0;
  int          rise_total = 0;

  function automatic bit is_nan(input logic [31:0] v);
    return (v & 32'h7FFF_FFFF) > 32'h7F80_0000;
  endfunction

  function automatic logic [2:0] fp_class(input logic [31:0] v);
    logic [31:0] a;
    a = v & 32'h7FFF_FFFF;
    if (a == 0) return 3'd0;
    if (a < 32'h0080_0000) return 3'd1;
    if (a < 32'h7F80_0000) return 3'd2;
    if (a == 32'h7F80_0000) return 3'd3;
    if (a >= 32'h7FC0_0000) return 3'd4;
    return 3'd5;
  endfunction

  // Length of the trailing run of identical non-NaN samples, counted in pairs.
  function automatic int trailing_equal();
    int n;
    n = 0;
    for (int i = samp_q.size() - 1; i > 0; i--) begin
      if (samp_q[i] == samp_q[i-1] && !is_nan(samp_q[i])) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_clear();
    samp_q.delete();
    m_stable = 0;
    m_phase  = M_ARMED;
  endtask

  always @(posedge clk) begin
    bit rise;
    if (!reset_n) begin
      m_phase = M_IDLE; samp_q.delete(); m_tick_prev = 1'b0;
      m_stable = 0; m_value = '0; m_class = '0;
    end else begin
      rise = tick_in && !m_tick_prev;
      m_tick_prev = tick_in;
      if (rise) rise_total++;
      case (m_phase)
        M_IDLE, M_FAIL: if (start) model_clear();
        M_ARMED: begin
          if (start) model_clear();
          else if (rise) begin
            samp_q.push_back(fp_in);
            m_stable = 0;
            m_phase  = M_TRACK;
          end
        end
        M_TRACK: begin
          if (start) model_clear();
          else if (rise) begin
            samp_q.push_back(fp_in);
            m_stable = trailing_equal();
            if (m_stable == SC) begin
              m_phase = M_HOLD; m_value = fp_in; m_class = fp_class(fp_in);
            end else if (samp_q.size() == TO) begin
              m_phase = M_FAIL;
            end
          end
        end
        M_HOLD: if (settled_ready) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
    #1;
    if (!done) begin
      check_eq("busy", busy, (m_phase == M_ARMED || m_phase == M_TRACK));
      check_eq("settled_valid", settled_valid, m_phase == M_HOLD);
      check_eq("timeout", timeout, m_phase == M_FAIL);
      check_eq("stable_cnt", stable_cnt, m_stable);
      check_eq("settled_value", settled_value, m_value);
      check_eq("settled_class", settled_class, m_class);
    end
  end

  // ---------------- driver tasks ----------------
  int base = 0;

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    base = rise_total;
  endtask

  task automatic wait_out(input bit want_timeout, input int budget, input string name,
                          output bit saw_valid, output int max_st);
    int  c;
    bit  hit;
    c = 0; saw_valid = 1'b0; max_st = 0;
    hit = want_timeout ? timeout : settled_valid;
    while (c < budget && !hit) begin
      @(negedge clk);
      c++;
      if (settled_valid) saw_valid = 1'b1;
      if (int'(stable_cnt) > max_st) max_st = int'(stable_cnt);
      hit = want_timeout ? timeout : settled_valid;
    end
    check_eq({name, "_reached"}, hit, 1'b1);
  endtask

  task automatic settle_run(input logic [31:0] v, input logic [2:0] cls, input string name);
    bit sv; int ms;
    fp_mode = 0; fp_a = v;
    pulse_start();
    wait_out(1'b0, 3000, name, sv, ms);
    check_eq({name, "_ticks"}, rise_total - base, SC + 1);
    check_eq({name, "_value"}, settled_value, v);
    check_eq({name, "_class"}, settled_class, cls);
    check_eq({name, "_timeout"}, timeout, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic timeout_run(input string name);
    bit sv; int ms;
    pulse_start();
    wait_out(1'b1, 4000, name, sv, ms);
    check_eq({name, "_ticks"}, rise_total - base, TO);
    check_eq({name, "_no_valid"}, sv, 1'b0);
    if (fp_mode == 1) check_eq({name, "_max_stable"}, ms, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit sv; int ms; int c;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_valid", settled_valid, 1'b0);
    check_eq("reset_timeout", timeout, 1'b0);
    check_eq("reset_stable", stable_cnt, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    settle_run(32'h3F80_0000, 3'd2, "one");

    fp_mode = 1; fp_a = 32'h4000_0000; fp_b = 32'h4000_0001;
    timeout_run("alternate");
    fp_mode = 0; fp_a = 32'h7FC0_0000;
    timeout_run("qnan");

    settle_run(32'h0000_0001, 3'd1, "subnormal");
    settle_run(32'h7F80_0000, 3'd3, "infinity");
    settle_run(32'h8000_0000, 3'd0, "neg_zero");

    // Consumer stalls: result must hold; a start during the hold is ignored.
    settled_ready = 1'b0; fp_mode = 0; fp_a = 32'hC049_0FDB;
    pulse_start();
    wait_out(1'b0, 3000, "stall", sv, ms);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      check_eq("stall_valid", settled_valid, 1'b1);
      check_eq("stall_value", settled_value, 32'hC049_0FDB);
      check_eq("stall_class", settled_class, 3'd2);
      check_eq("stall_busy", busy, 1'b0);
    end
    settled_ready = 1'b1;
    @(negedge clk);
    check_eq("release_valid", settled_valid, 1'b0);
    check_eq("release_busy", busy, 1'b0);

    // Reset mid-run clears everything immediately.
    fp_a = 32'h3F80_0000;
    pulse_start();
    c = 0;
    while (rise_total - base < 10 && c < 500) begin @(negedge clk); c++; end
    check_eq("reset_mid_reached", rise_total - base >= 10, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_busy", busy, 1'b0);
    check_eq("async_stable", stable_cnt, 0);
    check_eq("async_value", settled_value, 0);
    check_eq("async_class", settled_class, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    settle_run(32'h3F80_0000, 3'd2, "after_reset");

    // Restart mid-track: settle counted from the second start.
    pulse_start();
    c = 0;
    while (rise_total - base < 15 && c < 500) begin @(negedge clk); c++; end
    check_eq("restart_reached", rise_total - base >= 15, 1'b1);
    pulse_start();
    wait_out(1'b0, 3000, "restart", sv, ms);
    check_eq("restart_ticks", rise_total - base, SC + 1);
    repeat (2) @(negedge clk);

    // Random runs with sticky random data and random consumer back-pressure.
    for (int r = 0; r < 10; r++) begin
      fp_mode = 2; fp_a = $urandom; fp_b = fp_a ^ 32'h1;
      case ($urandom_range(0, 2))
        0: keep_pct = 80;
        1: keep_pct = 95;
        default: keep_pct = 100;
      endcase
      pulse_start();
      for (int k = 0; k < 3000; k++) begin
        @(negedge clk);
        settled_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 1999) == 0);
        if (m_phase == M_IDLE || m_phase == M_FAIL) break;
      end
      start = 1'b0;
      settled_ready = 1'b1;
      repeat (3) @(negedge clk);
    end

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_settle_monitor.md
Name: fp32_settle_monitor

Overview:
- Sits directly downstream of the op-amp/fraction converter stage. Consumes its 32-bit IEEE-754 single-precision output `square_out` and the converter's slow sampling clock `clk_100k`.
- Decides per run whether the converter output has settled: N consecutive identical samples within a tick budget.
- On settling, presents the settled word plus its IEEE-754 class on a valid/ready handshake. Otherwise it flags a timeout.
- One instance per converter channel; replaces ad-hoc stability counting with synthesizable RTL.

Parameters:
- STABLE_COUNT, 20, consecutive equal tick-to-tick comparisons required to declare settled (legal range 1..2^CNT_W-1).
- TIMEOUT_TICKS, 400, tick edges after arming without settling before FAIL (must exceed STABLE_COUNT).
- CNT_W, 10, width of stability and tick counters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins or restarts a monitoring run.
- tick_in  input  1  converter's clk_100k, already in the clk domain; only its rising edge is used.
- fp_in  input  32  converter output word (IEEE-754 single).
- busy  output  1  high in ARM or TRACK.
- settled_valid  output  1  settled result available.
- settled_ready  input  1  consumer accepts the result.
- settled_value  output  32  captured settled word.
- settled_class  output  3  class of the settled word: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 quiet NaN, 5 signalling NaN.
- timeout  output  1  run failed; held until the next start.
- stable_cnt  output  CNT_W  current consecutive-equal count, for debug.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal last-sample, tick counter and tick_q all 0.
- Tick detection:
  - tick_q registers tick_in; tick_rise = tick_in & ~tick_q.
  - fp_in is sampled only in the clk cycle where tick_rise is high.
- States:
  - IDLE: start -> ARM. Clears stable_cnt, tick counter and timeout.
  - ARM: on tick_rise, last = fp_in, tick counter = 1 -> TRACK.
  - TRACK: on each tick_rise, tick counter increments.
    - If fp_in == last (bitwise) and fp_in is not NaN, stable_cnt increments.
    - Otherwise stable_cnt = 0 and last = fp_in.
    - If the incremented stable_cnt equals STABLE_COUNT: settled_value = fp_in, settled_class computed from it -> HOLD.
    - Else, if the tick counter equals TIMEOUT_TICKS -> FAIL.
  - HOLD: settled_valid = 1. settled_value and settled_class are stable while valid and not ready. settled_valid & settled_ready -> IDLE, valid drops the next cycle.
  - FAIL: timeout = 1. start -> ARM (timeout clears).
- Comparison and classification rules:
  - +0 (0x00000000) and -0 (0x80000000) compare unequal.
  - Any NaN (exponent 0xFF, mantissa != 0) resets stable_cnt, so a NaN input can never settle.
  - Quiet NaN vs signalling NaN is decided by mantissa bit 22.
- Timing:
  - settled_valid asserts one clk after the deciding tick_rise cycle.
  - Minimum settle time is STABLE_COUNT+1 tick edges after ARM.
- Simultaneous events and edge cases:
  - Settle and timeout on the same tick: settle wins.
  - start in TRACK restarts from ARM (counters cleared).
  - start in HOLD is ignored.
  - start and tick_rise in the same IDLE cycle: go to ARM; that tick is not sampled.
- Counters:
  - stable_cnt saturates at 2^CNT_W-1.
  - The tick counter cannot wrap, because TIMEOUT_TICKS terminates the run first.
- Reset asserted mid-run aborts immediately to the IDLE reset values; no result is emitted.

Test Plan:
- Constant fp_in=0x3F800000, start, ready=1 -> settled_valid one clk after the 21st tick edge; settled_value=0x3F800000, class=2, timeout=0.
- fp_in alternating 0x40000000/0x40000001 every tick -> stable_cnt never exceeds 0; timeout=1 after tick 400; settled_valid never asserts.
- Constant fp_in=0x7FC00000 -> no settle, timeout at tick 400. Repeat with 0x00000001 -> settles with class=1; with 0x7F800000 -> class=3.
- Settle with settled_ready=0 for 50 clks -> valid, value and class held unchanged; ready pulse -> IDLE next cycle, busy=0.
- reset_n low at tick 10 of TRACK -> all outputs 0 asynchronously; after release, a new start plus a constant input settles normally.
- start re-pulsed at tick 15 with a constant input -> settle occurs 21 ticks after the restart, not after the original start.
